pixel_sink_writer: RTL and testbench
====================================

// Module: pixel_sink_writer
// PURPOSE
//  Receiving end of the drawer coordinate stream (x, y, colour, valid): glyph drawers emit
//  plot points; this block queues them, bounds-checks, converts to a linear framebuffer
//  address and writes the framebuffer port under its ready handshake. Also runs a full-screen
//  clear on request. Sits between the glyph drawers and the VGA framebuffer memory.
// PARAMETERS
//  X_W           8       x coordinate width
//  Y_W           7       y coordinate width
//  COLOUR_W      3       colour width
//  SCREEN_W      160     visible columns; valid x is 0..159
//  SCREEN_H      120     visible rows; valid y is 0..119
//  FIFO_DEPTH    4       input queue entries (power of 2)
//  CLEAR_COLOUR  3'b000  colour written by a clear
// PORTS
//  clk            in   1         50 MHz system clock
//  reset          in   1         asynchronous, active-high
//  in_x           in   X_W       pixel x
//  in_y           in   Y_W       pixel y
//  in_colour      in   COLOUR_W  pixel colour
//  in_valid       in   1         pixel offered
//  in_ready       out  1         pixel accepted when in_valid & in_ready at posedge
//  clear_req      in   1         request full-screen clear (level sampled at posedge)
//  fb_addr        out  15        y*SCREEN_W + x
//  fb_data        out  COLOUR_W  colour to write
//  fb_we          out  1         write strobe; held with addr/data until fb_ready
//  fb_ready       in   1         framebuffer accepts the write when fb_we & fb_ready
//  busy           out  1         state!=IDLE | FIFO not empty | fb_we
//  clear_done     out  1         1-cycle pulse after last clear write
//  dropped_count  out  8         out-of-range pixels discarded; saturates at 255
// BEHAVIOUR
//  - Reset (async): all outputs 0, FIFO empty, clear_pending 0, FSM IDLE; aborts any clear
//    with no clear_done. in_ready rises on the first edge after reset release.
//  - in_ready = !fifo_full & state!=CLEAR. No push when full even if a pop occurs that cycle.
//  - Output register: loads when (!fb_we | fb_ready) and FIFO not empty; pops head.
//    Head with x>=SCREEN_W or y>=SCREEN_H: popped, no write, dropped_count+1 (saturate).
//  - Latency: pixel accepted at edge N into empty FIFO with fb_we low -> fb_we high after
//    edge N+1. Sustained throughput 1 pixel/cycle while fb_ready=1.
//  - Address: (y<<7)+(y<<5)+x, 15-bit, max 19199; no wrap for in-range coordinates.
//  - FSM: IDLE -> CLEAR when clear_req|clear_pending, FIFO empty and no write outstanding;
//    clear_req while FIFO/write busy sets clear_pending (queued pixels drain first).
//    CLEAR: 15-bit counter 0..19199, fb_data=CLEAR_COLOUR, fb_we=1; counter advances only
//    on fb_ready. On acceptance of addr 19199 -> IDLE, clear_pending cleared, clear_done
//    pulses the next cycle. clear_req during CLEAR ignored (not queued).
//  - in_valid with in_ready low: stream holds values; nothing captured.
// STRUCTURE
//  - Shared package: SCREEN_W, SCREEN_H, FB_ADDR_W=15, coordinate/colour widths, FSM state
//    enum {IDLE, CLEAR}, CLEAR_COLOUR default.
//  - One sub-module: pixel_fifo (sync FIFO, FIFO_DEPTH x (X_W+Y_W+COLOUR_W), full/empty,
//    push/pop, registered storage). Top holds FSM, output register, address math, counters.
// TESTING
//  1. reset, then pixel (10,20,3'b101) -> fb_we after 2 edges, fb_addr=3210, fb_data=5, 1 write.
//  2. pixels (160,0) and (0,120) -> no fb_we, dropped_count=2; 300 bad pixels -> 255.
//  3. fb_ready=0, push 6 pixels -> in_ready low after 5 accepted (4 FIFO + 1 held); raise
//     fb_ready -> all 6 written in order, addr/data stable while stalled.
//  4. clear_req pulse, fb_ready=1 -> 19200 writes addr 0..19199 data 0, in_ready low,
//     clear_done one pulse one cycle after addr 19199.
//  5. 3 pixels queued + clear_req same cycle -> 3 pixel writes first, then clear sweep.
//  6. reset asserted at clear address 5000 -> outputs 0 immediately, no clear_done; next
//     pixel after release written normally.

Source files
------------

// File: rtl/pixel_sink_writer_pkg.sv
// Shared widths, screen geometry, FSM states and pixel payload for the framebuffer writer.
// Also holds the bounds check and the linear address helper used by the writer.
package pixel_sink_writer_pkg;

    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned COLOUR_W   = 3;
    localparam int unsigned SCREEN_W   = 160;
    localparam int unsigned SCREEN_H   = 120;
    localparam int unsigned FB_ADDR_W  = 15;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam logic [COLOUR_W-1:0]  CLEAR_COLOUR = COLOUR_W'(0);
    localparam logic [FB_ADDR_W-1:0] CLEAR_LAST   = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    localparam int unsigned PIXEL_W = $bits(pixel_t);

    function automatic logic in_range(input pixel_t p);
        return (p.x < X_W'(SCREEN_W)) && (p.y < Y_W'(SCREEN_H));
    endfunction

    // y*160 + x built from shifts; in-range coordinates never exceed 19199
    function automatic logic [FB_ADDR_W-1:0] fb_address(input pixel_t p);
        logic [FB_ADDR_W-1:0] y_ext;
        y_ext = FB_ADDR_W'(p.y);
        return (y_ext << 7) + (y_ext << 5) + FB_ADDR_W'(p.x);
    endfunction

endpackage

// File: rtl/pixel_sink_writer_fifo.sv
// Small synchronous FIFO for queued plot points; head word is always visible on rdata.
// Push while full and pop while empty are ignored.
module pixel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == CNT_W'(0));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/pixel_sink_writer.sv
// Queues drawer plot points, drops off-screen ones, and writes the framebuffer under fb_ready.
// Also sweeps the whole screen with CLEAR_COLOUR on request once queued pixels have drained.
module pixel_sink_writer
    import pixel_sink_writer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [X_W-1:0]       in_x,
    input  logic [Y_W-1:0]       in_y,
    input  logic [COLOUR_W-1:0]  in_colour,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clear_req,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COLOUR_W-1:0]  fb_data,
    output logic                 fb_we,
    input  logic                 fb_ready,
    output logic                 busy,
    output logic                 clear_done,
    output logic [7:0]           dropped_count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           state;
    logic             clear_pending;
    pixel_t           in_pixel;
    pixel_t           head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] cnt_nxt_c;
    logic             push_c;
    logic             load_c;
    logic             start_clear_c;
    logic             end_clear_c;
    logic             in_clear_nxt_c;

    assign in_pixel = '{x: in_x, y: in_y, colour: in_colour};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (load_c),
        .wdata (in_pixel),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Handshake, pop and FSM transition decisions for this cycle
    always_comb begin
        push_c         = in_valid && in_ready && !fifo_full;
        load_c         = (state == IDLE) && !fifo_empty && (!fb_we || fb_ready);
        start_clear_c  = (state == IDLE) && (clear_req || clear_pending) && fifo_empty && !fb_we;
        end_clear_c    = (state == CLEAR) && fb_ready && (fb_addr == CLEAR_LAST);
        in_clear_nxt_c = start_clear_c || ((state == CLEAR) && !end_clear_c);
        cnt_nxt_c      = fifo_count + CNT_W'(push_c) - CNT_W'(load_c);
    end

    assign busy = (state != IDLE) || !fifo_empty || fb_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            in_ready      <= 1'b0;
            fb_addr       <= '0;
            fb_data       <= '0;
            fb_we         <= 1'b0;
            clear_done    <= 1'b0;
            dropped_count <= '0;
        end else begin
            clear_done <= 1'b0;
            // in_ready tracks the post-edge occupancy so it is never high while full
            in_ready   <= (cnt_nxt_c != CNT_W'(FIFO_DEPTH)) && !in_clear_nxt_c;

            if (state == IDLE) begin
                if (start_clear_c) begin
                    state         <= CLEAR;
                    clear_pending <= 1'b0;
                    fb_we         <= 1'b1;
                    fb_addr       <= '0;
                    fb_data       <= CLEAR_COLOUR;
                end else begin
                    if (clear_req) begin
                        clear_pending <= 1'b1;
                    end
                    if (load_c) begin
                        if (in_range(head)) begin
                            fb_we   <= 1'b1;
                            fb_addr <= fb_address(head);
                            fb_data <= head.colour;
                        end else begin
                            fb_we <= 1'b0;
                            if (dropped_count != 8'hFF) begin
                                dropped_count <= dropped_count + 8'd1;
                            end
                        end
                    end else if (fb_ready) begin
                        fb_we <= 1'b0;
                    end
                end
            end else begin
                // Sweep advances only when the framebuffer takes the current word
                if (fb_ready) begin
                    if (end_clear_c) begin
                        state         <= IDLE;
                        fb_we         <= 1'b0;
                        clear_pending <= 1'b0;
                        clear_done    <= 1'b1;
                    end else begin
                        fb_addr <= fb_addr + FB_ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_sink_writer.sv
// Scoreboard bench for pixel_sink_writer: stimulus queues expected writes, a monitor checks
// every framebuffer strobe against the queue head and tracks clear_done timing.
module tb_pixel_sink_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_valid;
    logic        in_ready;
    logic        clear_req;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic        busy;
    logic        clear_done;
    logic [7:0]  dropped_count;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks     = 0;
    int  failures   = 0;
    int  writes     = 0;
    int  done_count = 0;
    logic done_due  = 1'b0;

    pixel_sink_writer dut (
        .clk           (clk),
        .reset         (reset),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_colour     (in_colour),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .clear_req     (clear_req),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fb_we         (fb_we),
        .fb_ready      (fb_ready),
        .busy          (busy),
        .clear_done    (clear_done),
        .dropped_count (dropped_count)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the queue head; clear_done only right after addr 19199
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_due = 1'b0;
            end else begin
                checks++;
                if (clear_done !== done_due) begin
                    failures++;
                    $display("FAIL clear_done actual=%0d expected=%0d", clear_done, done_due);
                end
                if (clear_done === 1'b1) done_count++;
                if (fb_we === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write addr=%0d data=%0d", fb_addr, fb_data);
                    end else begin
                        e = exp_q[0];
                        if (fb_addr !== e.addr || fb_data !== e.data) begin
                            failures++;
                            $display("FAIL write addr=%0d data=%0d expected addr=%0d data=%0d",
                                     fb_addr, fb_data, e.addr, e.data);
                        end
                        if (fb_ready) begin
                            void'(exp_q.pop_front());
                            writes++;
                        end
                    end
                end
                done_due = (fb_we === 1'b1) && fb_ready && (fb_addr == 15'd19199) && (fb_data == 3'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input int c);
        logic acc;
        wr_t  e;
        in_x      = 8'(x);
        in_y      = 7'(y);
        in_colour = 3'(c);
        in_valid  = 1'b1;
        if (x < 160 && y < 120) begin
            e.addr = 15'(y * 160 + x);
            e.data = 3'(c);
            exp_q.push_back(e);
        end
        acc = 1'b0;
        for (int i = 0; i < 30000 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=0 expected=1");
        end
    endtask

    task automatic push_clear_exp();
        wr_t e;
        for (int a = 0; a < 19200; a++) begin
            e.addr = 15'(a);
            e.data = 3'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && (exp_q.size() == 0);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout pending=%0d busy=%0d", exp_q.size(), busy);
        end
        step();
    endtask

    initial begin : stimulus
        int   w0;
        int   d0;
        logic found;
        reset     = 1'b1;
        in_x      = '0;
        in_y      = '0;
        in_colour = '0;
        in_valid  = 1'b0;
        clear_req = 1'b0;
        fb_ready  = 1'b1;
        #25;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dropped", dropped_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("release_in_ready_low", in_ready, 0);
        step();
        chk("release_in_ready_high", in_ready, 1);

        // 1: single pixel latency and address
        w0 = writes;
        in_x = 8'd10; in_y = 7'd20; in_colour = 3'b101; in_valid = 1'b1;
        exp_q.push_back('{addr: 15'd3210, data: 3'd5});
        step();
        in_valid = 1'b0;
        chk("lat_edge1_we", fb_we, 0);
        step();
        chk("lat_edge2_we", fb_we, 1);
        chk("t1_addr", fb_addr, 3210);
        chk("t1_data", fb_data, 5);
        wait_idle();
        chk("t1_writes", writes - w0, 1);

        // 2: out-of-range pixels dropped, counter saturates
        w0 = writes;
        send(160, 0, 1);
        send(0, 120, 2);
        wait_idle();
        chk("t2_dropped2", dropped_count, 2);
        for (int i = 0; i < 300; i++) send(200 + (i % 50), i % 128, i % 8);
        wait_idle();
        chk("t2_saturate", dropped_count, 255);
        chk("t2_no_writes", writes - w0, 0);

        // 3: backpressure fills FIFO + output register
        w0 = writes;
        fb_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(k * 3, k + 1, k + 1);
        step();
        chk("t3_in_ready_low", in_ready, 0);
        in_x = 8'd100; in_y = 7'd50; in_colour = 3'd7; in_valid = 1'b1;
        repeat (3) step();
        chk("t3_still_low", in_ready, 0);
        chk("t3_stalled_writes", writes - w0, 0);
        in_valid = 1'b0;
        fb_ready = 1'b1;
        send(100, 50, 7);
        wait_idle();
        chk("t3_writes", writes - w0, 6);

        // 4: full-screen clear
        w0 = writes;
        d0 = done_count;
        push_clear_exp();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        chk("t4_in_ready_low", in_ready, 0);
        chk("t4_busy", busy, 1);
        wait_idle();
        chk("t4_writes", writes - w0, 19200);
        chk("t4_done_pulses", done_count - d0, 1);
        chk("t4_in_ready_back", in_ready, 1);

        // 5: queued pixels drain before a clear requested alongside them
        w0 = writes;
        d0 = done_count;
        fb_ready = 1'b0;
        send(1, 1, 1);
        send(2, 2, 2);
        clear_req = 1'b1;
        send(3, 3, 3);
        clear_req = 1'b0;
        push_clear_exp();
        repeat (2) step();
        fb_ready = 1'b1;
        wait_idle();
        chk("t5_writes", writes - w0, 19203);
        chk("t5_done_pulses", done_count - d0, 1);

        // 6: reset in the middle of a clear
        d0 = done_count;
        push_clear_exp();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            found = fb_we && (fb_addr == 15'd5000);
        end
        chk("t6_reach_5000", found, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_fb_we", fb_we, 0);
        chk("t6_fb_addr", fb_addr, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_busy", busy, 0);
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        chk("t6_in_ready_after", in_ready, 1);
        w0 = writes;
        send(5, 6, 2);
        wait_idle();
        chk("t6_pixel_written", writes - w0, 1);
        chk("t6_dropped_cleared", dropped_count, 0);
        chk("t6_no_done", done_count - d0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
